sha1_job_controller: RTL and testbench

SHA1_JOB_CONTROLLER -- requirements
Module: sha1_job_controller

---
 rtl/sha1_ctrl_pkg.sv | 17 +
 rtl/sha1_digest_buf.sv | 38 +++
 rtl/sha1_job_controller.sv | 195 +++++++++++++++++++
 tb/tb_sha1_job_controller.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_ctrl_pkg.sv
// Shared types and constants for the SHA-1 job controller.
// Used by sha1_job_controller and sha1_digest_buf.
package sha1_ctrl_pkg;

   typedef enum logic [2:0] {LOAD, START, POLL, RD_DIG, OUT} ctrl_state_e;

   localparam int MSG_WORDS    = 16;
   localparam int DIGEST_WORDS = 5;
   localparam int START_BIT    = 0;
   localparam int DONE_BIT     = 1;

   localparam logic [31:0] DEF_CSR_ADDR     = 32'd0;
   localparam logic [31:0] DEF_MSG_BASE     = 32'd1;
   localparam logic [31:0] DEF_DIGEST_BASE  = 32'd17;
   localparam int          DEF_POLL_TIMEOUT = 4096;

endpackage

// File: rtl/sha1_digest_buf.sv
// Five-word digest buffer: filled from slave reads, drained as a valid/ready
// stream with out_last flagging H4.
module sha1_digest_buf
   import sha1_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic [2:0]  wr_idx,
   input  logic [31:0] wr_data,
   input  logic        rd_active,
   input  logic [2:0]  rd_idx,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        out_fire
);

   logic [31:0] digest_q [DIGEST_WORDS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DIGEST_WORDS; k++) digest_q[k] <= '0;
      end else if (wr_en && (wr_idx < 3'(DIGEST_WORDS))) begin
         digest_q[wr_idx] <= wr_data;
      end
   end

   // Data is gated by valid so the stream reads as zero outside OUT.
   always_comb begin
      out_valid = rd_active && (rd_idx < 3'(DIGEST_WORDS));
      out_data  = out_valid ? digest_q[rd_idx] : '0;
      out_last  = out_valid && (rd_idx == 3'(DIGEST_WORDS - 1));
      out_fire  = out_valid && out_ready;
   end

endmodule

// File: rtl/sha1_job_controller.sv
// Streams one 512-bit block into a SHA-1 wrapper slave, polls for done and
// streams the digest out. Define SHA1_CTRL_TIMEOUT_EN to enable the poll timeout.
module sha1_job_controller
   import sha1_ctrl_pkg::*;
#(
   parameter logic [31:0] CSR_ADDR     = DEF_CSR_ADDR,
   parameter logic [31:0] MSG_BASE     = DEF_MSG_BASE,
   parameter logic [31:0] DIGEST_BASE  = DEF_DIGEST_BASE,
   parameter int          POLL_TIMEOUT = DEF_POLL_TIMEOUT
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        m_write,
   output logic        m_read,
   output logic [31:0] m_address,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   output logic        busy,
   output logic        err
);

   ctrl_state_e state_q, state_d;
   logic [3:0]  word_cnt_q, word_cnt_d;
   logic        full_q, full_d;
   logic        wr_pend_q, wr_pend_d;
   logic [3:0]  wr_idx_q, wr_idx_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic [2:0]  dig_idx_q, dig_idx_d;
   logic        phase_q, phase_d;
   logic        live_q;
   logic        dig_we;
   logic        out_fire;
   logic        timeout;

   // live_q keeps in_ready low until the first clock after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= LOAD;
         word_cnt_q <= '0;
         full_q     <= 1'b0;
         wr_pend_q  <= 1'b0;
         wr_idx_q   <= '0;
         wr_data_q  <= '0;
         dig_idx_q  <= '0;
         phase_q    <= 1'b0;
         live_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         full_q     <= full_d;
         wr_pend_q  <= wr_pend_d;
         wr_idx_q   <= wr_idx_d;
         wr_data_q  <= wr_data_d;
         dig_idx_q  <= dig_idx_d;
         phase_q    <= phase_d;
         live_q     <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      full_d      = full_q;
      wr_pend_d   = 1'b0;
      wr_idx_d    = wr_idx_q;
      wr_data_d   = wr_data_q;
      dig_idx_d   = dig_idx_q;
      phase_d     = phase_q;
      in_ready    = 1'b0;
      m_write     = 1'b0;
      m_read      = 1'b0;
      m_address   = '0;
      m_writedata = '0;
      dig_we      = 1'b0;

      case (state_q)
         // Each accepted word is written one cycle later; word 15 sets full_q,
         // which closes in_ready while its write drains.
         LOAD: begin
            in_ready = live_q && !full_q;
            m_write  = wr_pend_q;
            if (wr_pend_q) begin
               m_address   = MSG_BASE + 32'(wr_idx_q);
               m_writedata = wr_data_q;
            end
            if (in_valid && in_ready) begin
               wr_pend_d = 1'b1;
               wr_idx_d  = word_cnt_q;
               wr_data_d = in_data;
               if (word_cnt_q == 4'(MSG_WORDS - 1)) full_d = 1'b1;
               else                                 word_cnt_d = word_cnt_q + 4'd1;
            end else if (full_q) begin
               full_d     = 1'b0;
               word_cnt_d = '0;
               state_d    = START;
            end
         end
         START: begin
            m_write     = 1'b1;
            m_address   = CSR_ADDR;
            m_writedata = 32'(1 << START_BIT);
            phase_d     = 1'b0;
            state_d     = POLL;
         end
         POLL: begin
            m_read    = 1'b1;
            m_address = CSR_ADDR;
            phase_d   = !phase_q;
            if (phase_q && m_readdata[DONE_BIT]) begin
               phase_d   = 1'b0;
               dig_idx_d = '0;
               state_d   = RD_DIG;
            end else if (timeout) begin
               phase_d = 1'b0;
               state_d = LOAD;
            end
         end
         // Address phase then sample phase for each of H0..H4.
         RD_DIG: begin
            m_read    = 1'b1;
            m_address = DIGEST_BASE + 32'(dig_idx_q);
            phase_d   = !phase_q;
            if (phase_q) begin
               dig_we = 1'b1;
               if (dig_idx_q == 3'(DIGEST_WORDS - 1)) begin
                  dig_idx_d = '0;
                  state_d   = OUT;
               end else begin
                  dig_idx_d = dig_idx_q + 3'd1;
               end
            end
         end
         OUT: begin
            if (out_fire) begin
               if (dig_idx_q == 3'(DIGEST_WORDS - 1)) begin
                  dig_idx_d = '0;
                  state_d   = LOAD;
               end else begin
                  dig_idx_d = dig_idx_q + 3'd1;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   assign busy = (state_q != LOAD) || (word_cnt_q != 4'd0);

`ifdef SHA1_CTRL_TIMEOUT_EN
   logic [15:0] poll_cnt_q;
   logic        err_q;

   // Counter is held clear outside POLL, so it restarts on every entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         poll_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         err_q      <= (state_q == POLL) && (state_d == LOAD);
         poll_cnt_q <= (state_q == POLL) ? poll_cnt_q + 16'd1 : 16'd0;
      end
   end

   assign timeout = (state_q == POLL) && (poll_cnt_q == 16'(POLL_TIMEOUT - 1));
   assign err     = err_q;
`else
   logic unused_poll_timeout;
   assign unused_poll_timeout = ^POLL_TIMEOUT;
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   sha1_digest_buf u_digest_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en     (dig_we),
      .wr_idx    (dig_idx_q),
      .wr_data   (m_readdata),
      .rd_active (state_q == OUT),
      .rd_idx    (dig_idx_q),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_fire  (out_fire)
   );

endmodule

// File: tb/tb_sha1_job_controller.sv
// Self-checking bench for sha1_job_controller with a behavioural SHA-1 wrapper slave.
// The timeout scenario is built only when SHA1_CTRL_TIMEOUT_EN is defined.
module tb_sha1_job_controller;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_last;
   logic        m_write, m_read;
   logic [31:0] m_address, m_writedata;
   logic [31:0] m_readdata = '0;
   logic        busy, err;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [31:0] ABC_DIG [5] = '{32'ha9993e36, 32'h4706816a, 32'hba3e2571,
                                           32'h7850c26c, 32'h9cd0d89d};

   logic [31:0] smem [22];
   logic [31:0] slave_blk [16];
   logic [159:0] slave_h;
   int          done_cnt = 0;
   bit          never_done = 1'b0;
   logic [63:0] wr_log [$];
   int          err_pulses = 0;
   int          outv_seen = 0;
   logic [31:0] abc_w [16];

   sha1_job_controller #(.POLL_TIMEOUT(64)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .m_write     (m_write),
      .m_read      (m_read),
      .m_address   (m_address),
      .m_writedata (m_writedata),
      .m_readdata  (m_readdata),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   function automatic logic [159:0] sha1_block(input logic [31:0] m [16]);
      logic [31:0] w [80];
      logic [31:0] a, b, c, d, e, f, k, t;
      for (int i = 0; i < 16; i++) w[i] = m[i];
      for (int i = 16; i < 80; i++) begin
         t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
         w[i] = {t[30:0], t[31]};
      end
      a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
      for (int i = 0; i < 80; i++) begin
         if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
         else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
         else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
         else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
         t = {a[26:0], a[31:27]} + f + e + k + w[i];
         e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
      end
      return {a + 32'h67452301, b + 32'hEFCDAB89, c + 32'h98BADCFE,
              d + 32'h10325476, e + 32'hC3D2E1F0};
   endfunction

   // Wrapper slave: one-cycle writes, registered reads, done after a random delay.
   initial for (int i = 0; i < 22; i++) smem[i] = '0;

   always @(posedge clk) begin
      if (m_read) m_readdata <= (m_address < 32'd22) ? smem[m_address] : 32'hdeadbeef;
      if (done_cnt > 0) begin
         done_cnt = done_cnt - 1;
         if (done_cnt == 0) begin
            for (int i = 0; i < 16; i++) slave_blk[i] = smem[1+i];
            slave_h = sha1_block(slave_blk);
            for (int i = 0; i < 5; i++) smem[17+i] = slave_h[159-32*i -: 32];
            smem[0] = 32'h2;
         end
      end
      if (m_write && m_address < 32'd22) begin
         smem[m_address] = m_writedata;
         if (m_address == 32'd0 && m_writedata[0]) begin
            smem[0] = '0;
            if (!never_done) done_cnt = $urandom_range(3, 30);
         end
      end
   end

   always @(negedge clk) begin
      if (m_write) wr_log.push_back({m_address, m_writedata});
      if (err) err_pulses++;
      if (out_valid) outv_seen++;
      if (m_write || m_read) begin
         vectors++;
         if (m_write && m_read) begin
            miscompares++;
            $display("[TB] FAIL bus_exclusive: m_write=%b m_read=%b, required not both 1", m_write, m_read);
         end
      end
   end

   task automatic send_word(input logic [31:0] w, output bit ok);
      int t = 0;
      in_valid = 1'b1;
      in_data  = w;
      @(negedge clk);
      while (!in_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      ok = in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_job(input logic [31:0] w [16], input int max_gap, output bit ok);
      bit one;
      ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
         send_word(w[i], one);
         ok &= one;
      end
   endtask

   task automatic get_digest(input bit rand_ready, output logic [31:0] d [5],
                             output logic [4:0] last, output bit ok);
      int k = 0;
      int t = 0;
      last = '0;
      for (int i = 0; i < 5; i++) d[i] = '0;
      while (k < 5 && t < 5000) begin
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (out_valid && out_ready) begin
            d[k]    = out_data;
            last[k] = out_last;
            k++;
         end
         @(posedge clk); #1;
         t++;
      end
      out_ready = 1'b0;
      ok = (k == 5);
   endtask

   task automatic test_reset();
      @(negedge clk);
      vectors++;
      if ({in_ready, out_valid, out_last, out_data, m_write, m_read, m_address,
           m_writedata, busy, err} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: in_ready=%b out_valid=%b m_write=%b m_read=%b m_address=%h busy=%b, required all 0",
                  in_ready, out_valid, m_write, m_read, m_address, busy);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_release_ready: in_ready=%b, required 0", in_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ready_after_reset: in_ready=%b busy=%b, required 1/0", in_ready, busy);
      end
   endtask

   task automatic test_abc();
      logic [31:0] d [5];
      logic [4:0]  last;
      bit          ok_in, ok_out;
      wr_log.delete();
      send_job(abc_w, 0, ok_in);
      get_digest(1'b0, d, last, ok_out);
      vectors++;
      if (!ok_in || !ok_out) begin
         miscompares++;
         $display("[TB] FAIL abc_timeout: in_ok=%b out_ok=%b, required 1/1", ok_in, ok_out);
      end
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (d[i] !== ABC_DIG[i]) begin
            miscompares++;
            $display("[TB] FAIL abc_h%0d: got %h, required %h", i, d[i], ABC_DIG[i]);
         end
      end
      vectors++;
      if (last !== 5'b10000) begin
         miscompares++;
         $display("[TB] FAIL abc_last: got %b, required 10000", last);
      end
   endtask

   task automatic test_gaps();
      logic [31:0] w [16];
      logic [31:0] d [5];
      logic [4:0]  last;
      logic [63:0] exp_wr;
      logic [159:0] exp;
      bit          ok_in, ok_out;
      for (int job = 0; job < 3; job++) begin
         for (int i = 0; i < 16; i++) w[i] = $urandom;
         exp = sha1_block(w);
         wr_log.delete();
         send_job(w, 3, ok_in);
         get_digest(1'b1, d, last, ok_out);
         vectors++;
         if (!ok_in || !ok_out || {d[0], d[1], d[2], d[3], d[4]} !== exp) begin
            miscompares++;
            $display("[TB] FAIL gaps_digest job%0d: got %h %h %h %h %h, required %h", job,
                     d[0], d[1], d[2], d[3], d[4], exp);
         end
         vectors++;
         if (wr_log.size() != 17) begin
            miscompares++;
            $display("[TB] FAIL gaps_write_count job%0d: got %0d, required 17", job, wr_log.size());
         end else begin
            for (int i = 0; i < 17; i++) begin
               exp_wr = (i < 16) ? {32'(i + 1), w[i]} : {32'd0, 32'd1};
               vectors++;
               if (wr_log[i] !== exp_wr) begin
                  miscompares++;
                  $display("[TB] FAIL gaps_write%0d job%0d: got %h, required %h", i, job, wr_log[i], exp_wr);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d [5];
      logic [4:0]  last;
      bit          ok_in, ok_out;
      int          t = 0;
      send_job(abc_w, 0, ok_in);
      out_ready = 1'b0;
      @(negedge clk);
      while (!out_valid && t < 2000) begin
         @(negedge clk);
         t++;
      end
      for (int i = 0; i < 20; i++) begin
         vectors++;
         if (out_valid !== 1'b1 || out_data !== ABC_DIG[0] || out_last !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stall_hold cyc%0d: valid=%b data=%h last=%b, required 1/%h/0",
                     i, out_valid, out_data, out_last, ABC_DIG[0]);
         end
         @(negedge clk);
      end
      @(posedge clk); #1;
      get_digest(1'b0, d, last, ok_out);
      vectors++;
      if (!ok_in || !ok_out || d !== ABC_DIG || last !== 5'b10000) begin
         miscompares++;
         $display("[TB] FAIL stall_digest: got %h %h %h %h %h last=%b, required abc digest last=10000",
                  d[0], d[1], d[2], d[3], d[4], last);
      end
   endtask

   task automatic test_reset_mid_job();
      logic [31:0] d [5];
      logic [4:0]  last;
      bit          ok_in, ok_out;
      for (int i = 0; i < 7; i++) begin
         send_word($urandom, ok_in);
      end
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         vectors++;
         if ({in_ready, out_valid, out_last, out_data, m_write, m_read, m_address,
              m_writedata, busy, err} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midjob_reset_outputs cyc%0d: in_ready=%b m_write=%b m_address=%h busy=%b, required all 0",
                     i, in_ready, m_write, m_address, busy);
         end
         @(posedge clk); #1;
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
      wr_log.delete();
      send_job(abc_w, 1, ok_in);
      get_digest(1'b1, d, last, ok_out);
      vectors++;
      if (!ok_in || !ok_out || d !== ABC_DIG) begin
         miscompares++;
         $display("[TB] FAIL midjob_rerun_digest: got %h %h %h %h %h, required abc digest",
                  d[0], d[1], d[2], d[3], d[4]);
      end
      vectors++;
      if (wr_log.size() != 17) begin
         miscompares++;
         $display("[TB] FAIL midjob_write_count: got %0d, required 17", wr_log.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w1 [16];
      logic [31:0] w2 [16];
      logic [31:0] d1 [5];
      logic [31:0] d2 [5];
      logic [4:0]  last;
      bit          ok1, ok2, ok3, ok4;
      logic        rdy;
      for (int i = 0; i < 16; i++) begin
         w1[i] = $urandom;
         w2[i] = $urandom;
      end
      send_job(w1, 0, ok1);
      get_digest(1'b0, d1, last, ok2);
      rdy = in_ready;
      send_job(w2, 0, ok3);
      get_digest(1'b0, d2, last, ok4);
      vectors++;
      if (rdy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL b2b_ready: in_ready=%b after H4, required 1", rdy);
      end
      vectors++;
      if (!ok1 || !ok2 || {d1[0], d1[1], d1[2], d1[3], d1[4]} !== sha1_block(w1)) begin
         miscompares++;
         $display("[TB] FAIL b2b_digest1: got %h %h %h %h %h, required %h",
                  d1[0], d1[1], d1[2], d1[3], d1[4], sha1_block(w1));
      end
      vectors++;
      if (!ok3 || !ok4 || {d2[0], d2[1], d2[2], d2[3], d2[4]} !== sha1_block(w2)) begin
         miscompares++;
         $display("[TB] FAIL b2b_digest2: got %h %h %h %h %h, required %h",
                  d2[0], d2[1], d2[2], d2[3], d2[4], sha1_block(w2));
      end
   endtask

`ifdef SHA1_CTRL_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] w [16];
      bit          ok_in;
      for (int i = 0; i < 16; i++) w[i] = $urandom;
      never_done = 1'b1;
      err_pulses = 0;
      outv_seen  = 0;
      send_job(w, 0, ok_in);
      repeat (300) @(negedge clk);
      vectors++;
      if (!ok_in || err_pulses != 1 || outv_seen != 0) begin
         miscompares++;
         $display("[TB] FAIL timeout_err: err cycles=%0d out_valid cycles=%0d, required 1/0",
                  err_pulses, outv_seen);
      end
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL timeout_return: in_ready=%b busy=%b, required 1/0", in_ready, busy);
      end
      never_done = 1'b0;
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      for (int i = 0; i < 16; i++) abc_w[i] = '0;
      abc_w[0]  = 32'h61626380;
      abc_w[15] = 32'h00000018;
      test_reset();
      test_abc();
      test_gaps();
      test_backpressure();
      test_reset_mid_job();
      test_back_to_back();
`ifdef SHA1_CTRL_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
